// File: rtl/ov7670_stream_tx.sv
// OV7670-style camera bus transmitter.
// Takes 24-bit RGB pixels from an AXI-Stream source and emits RGB565 bytes,
// high byte first, with vsync/href framing. Frame timing is free-running and
// never waits on the source: a missing pixel becomes two zero bytes.
module ov7670_stream_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        pclk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        clear_flags,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        busy,
    output logic        frame_done,
    output logic        underflow,
    output logic        tlast_err
);

    localparam int L  = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(L);
    localparam int LW = 16;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t        r_state, w_next;
    logic [HW-1:0] r_hcnt;
    logic [LW-1:0] r_lcnt, w_nlines;
    logic          w_line_end, w_state_end, w_inline, w_accept;
    logic          w_idx_last, w_underflow_ev, w_tlast_ev;
    logic [7:0]    w_byte0, w_byte1, r_byte1, r_data;
    logic          r_vsync, r_href, r_frame_done, r_underflow, r_tlast_err;
    logic          w_unused_bits;

    assign w_line_end  = (r_hcnt == HW'(L - 1));
    assign w_state_end = w_line_end && (r_lcnt == w_nlines - LW'(1));

    // In-line means the first 2*H_ACTIVE cycles of an ACTIVE line; even cycles take a pixel.
    assign w_inline       = (r_state == ACTIVE) && (r_hcnt < HW'(2 * H_ACTIVE));
    assign s_axis_tready  = w_inline && !r_hcnt[0];
    assign w_accept       = s_axis_tready && s_axis_tvalid;
    assign w_idx_last     = (r_hcnt[HW-1:1] == (HW-1)'(H_ACTIVE - 1));
    assign w_underflow_ev = s_axis_tready && !s_axis_tvalid;
    assign w_tlast_ev     = w_accept && (s_axis_tlast != w_idx_last);

    // RGB565 packing: {R[7:3],G[7:5]} then {G[4:2],B[7:3]}
    assign w_byte0 = {s_axis_tdata[23:19], s_axis_tdata[15:13]};
    assign w_byte1 = {s_axis_tdata[12:10], s_axis_tdata[7:3]};
    assign w_unused_bits = &{1'b0, s_axis_tdata[31:24], s_axis_tdata[18:16],
                             s_axis_tdata[9:8], s_axis_tdata[2:0]};

    // Number of line periods spent in the current state
    always_comb begin
        w_nlines = '0;
        case (r_state)
            VSYNC:   w_nlines = LW'(V_SYNC);
            VBACK:   w_nlines = LW'(V_BACK);
            ACTIVE:  w_nlines = LW'(V_ACTIVE);
            VFRONT:  w_nlines = LW'(V_FRONT);
            default: w_nlines = '0;
        endcase
    end

    // Next-state logic; a started frame always runs to the end of VFRONT
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable)      w_next = VSYNC;
            VSYNC:   if (w_state_end) w_next = VBACK;
            VBACK:   if (w_state_end) w_next = ACTIVE;
            ACTIVE:  if (w_state_end) w_next = VFRONT;
            VFRONT:  if (w_state_end) w_next = enable ? VSYNC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pclk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Horizontal counter wraps each line; line counter restarts on every state change
    always_ff @(posedge pclk) begin
        if (!resetn || r_state == IDLE) begin
            r_hcnt <= '0;
            r_lcnt <= '0;
        end else begin
            r_hcnt <= w_line_end ? '0 : r_hcnt + HW'(1);
            r_lcnt <= w_state_end ? '0 : (w_line_end ? r_lcnt + LW'(1) : r_lcnt);
        end
    end

    // Registered camera bus: byte0 follows the accept cycle, byte1 the cycle after
    always_ff @(posedge pclk) begin
        if (!resetn) begin
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_vsync      <= (r_state == VSYNC);
            r_href       <= w_inline;
            r_frame_done <= (r_state == VFRONT) && w_state_end;
            if (s_axis_tready) r_data <= s_axis_tvalid ? w_byte0 : 8'h00;
            else if (w_inline) r_data <= r_byte1;
            else               r_data <= 8'h00;
        end
    end

    // Second byte of the pixel held for the phase-1 cycle
    always_ff @(posedge pclk) begin
        if (s_axis_tready) r_byte1 <= s_axis_tvalid ? w_byte1 : 8'h00;
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge pclk) begin
        if (!resetn) begin
            r_underflow <= 1'b0;
            r_tlast_err <= 1'b0;
        end else begin
            if (w_underflow_ev)   r_underflow <= 1'b1;
            else if (clear_flags) r_underflow <= 1'b0;
            if (w_tlast_ev)       r_tlast_err <= 1'b1;
            else if (clear_flags) r_tlast_err <= 1'b0;
        end
    end

    assign vsync      = r_vsync;
    assign href       = r_href;
    assign data       = r_data;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign underflow  = r_underflow;
    assign tlast_err  = r_tlast_err;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Testbench for ov7670_stream_tx with a small frame geometry (L = 12 cycles,
// 5 lines per frame). A source process feeds pixels and queues the expected
// bytes; a monitor process pops and compares whenever href is high.
module tb_ov7670_stream_tx;

    localparam logic [31:0] PIX [4] = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00FFFFFF};
    localparam logic [7:0]  EB0 [4] = '{8'hF8, 8'h07, 8'h00, 8'hFF};
    localparam logic [7:0]  EB1 [4] = '{8'h00, 8'hE0, 8'h1F, 8'hFF};

    logic        pclk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        clear_flags = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        vsync, href, busy, frame_done, underflow, tlast_err;
    logic [7:0]  data;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   per_chk = 0;
    bit   clr_on_drop = 0;
    int   drop_req = 0, drop_done = 0;
    int   tl_req = 0, tl_done = 0;
    int   clr_req = 0, clr_done = 0;
    int   slot = 0;
    bit   line_bad = 0;
    bit   d_drop;
    logic [7:0] q[$];
    int   run = 0, f_vs = 0, f_hr = 0, f_tr = 0, fd_prev = -1;

    ov7670_stream_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .resetn(resetn), .enable(enable), .clear_flags(clear_flags),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .vsync(vsync), .href(href), .data(data), .busy(busy),
        .frame_done(frame_done), .underflow(underflow), .tlast_err(tlast_err)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Source: presents a pixel on each tready cycle and queues its expected bytes
    always @(negedge pclk) begin
        if (!resetn) begin
            slot = 0;
            line_bad = 0;
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            s_axis_tdata = '0;
            clear_flags = 1'b0;
        end else begin
            clear_flags = 1'b0;
            if (clr_req != clr_done) begin
                clear_flags = 1'b1;
                clr_done++;
            end
            if (s_axis_tready) begin
                if (slot == 0 && tl_req != tl_done) begin
                    line_bad = 1;
                    tl_done++;
                end
                d_drop = (slot == 2) && (drop_req != drop_done);
                if (d_drop) begin
                    drop_done++;
                    if (clr_on_drop) clear_flags = 1'b1;
                end
                s_axis_tvalid = !d_drop;
                s_axis_tdata = PIX[slot];
                s_axis_tlast = line_bad ? (slot == 2) : (slot == 3);
                if (d_drop) begin
                    q.push_back(8'h00);
                    q.push_back(8'h00);
                end else begin
                    q.push_back(EB0[slot]);
                    q.push_back(EB1[slot]);
                end
                slot = (slot + 1) % 4;
                if (slot == 0) line_bad = 0;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast = 1'b0;
                s_axis_tdata = '0;
            end
        end
    end

    // Monitor: byte scoreboard, href run length, per-frame vsync/href/tready totals
    always @(negedge pclk) begin
        if (!resetn) begin
            run = 0; f_vs = 0; f_hr = 0; f_tr = 0; fd_prev = -1;
        end else begin
            if (frame_done) begin
                check("frame_vsync_cycles", f_vs, 12);
                check("frame_href_cycles", f_hr, 16);
                check("frame_tready_cycles", f_tr, 8);
                if (per_chk && fd_prev >= 0) check("frame_done_period", cyc - fd_prev, 60);
                fd_prev = cyc;
                f_vs = 0; f_hr = 0; f_tr = 0;
            end
            f_vs += int'(vsync);
            f_hr += int'(href);
            f_tr += int'(s_axis_tready);
            if (href) begin
                run++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte_unexpected: got %0h with href=1, expected no byte (t=%0t)", data, $time);
                end else begin
                    check("byte", int'(data), int'(q.pop_front()));
                end
            end else begin
                if (run != 0) check("href_run_length", run, 8);
                run = 0;
                check("data_zero_when_href_low", int'(data), 0);
            end
        end
    end

    task automatic wait_fd(input int bound);
        bit seen = 0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge pclk);
            if (frame_done) seen = 1;
        end
        check("frame_done_seen", int'(seen), 1);
    endtask

    task automatic wait_tready(input int bound);
        bit seen = 0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge pclk);
            if (s_axis_tready) seen = 1;
        end
        check("tready_seen", int'(seen), 1);
    endtask

    task automatic idle_window(input int n);
        int nv = 0, nb = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            nv += int'(vsync);
            nb += int'(busy);
        end
        check("idle_vsync_cycles", nv, 0);
        check("idle_busy_cycles", nb, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vsync"}, int'(vsync), 0);
        check({tag, "_href"}, int'(href), 0);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_underflow"}, int'(underflow), 0);
        check({tag, "_tlast_err"}, int'(tlast_err), 0);
        check({tag, "_tready"}, int'(s_axis_tready), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge pclk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge pclk);
        check("idle_busy", int'(busy), 0);

        // Continuous frames, clean source
        per_chk = 1;
        enable = 1'b1;
        wait_fd(100);
        wait_fd(100);
        check("clean_underflow", int'(underflow), 0);
        check("clean_tlast_err", int'(tlast_err), 0);

        // Missing pixel 2 on line 0
        drop_req++;
        wait_fd(100);
        check("drop_underflow", int'(underflow), 1);
        check("drop_tlast_err", int'(tlast_err), 0);
        repeat (5) @(negedge pclk);
        check("underflow_sticky", int'(underflow), 1);
        clr_req++;
        repeat (3) @(negedge pclk);
        check("underflow_cleared", int'(underflow), 0);

        // Underflow event and clear_flags on the same edge
        clr_on_drop = 1;
        drop_req++;
        wait_fd(100);
        check("set_beats_clear", int'(underflow), 1);
        clr_on_drop = 0;
        clr_req++;
        repeat (3) @(negedge pclk);
        check("underflow_cleared2", int'(underflow), 0);

        // tlast on pixel 2 instead of 3
        tl_req++;
        wait_fd(100);
        check("tlast_err_set", int'(tlast_err), 1);
        check("tlast_no_underflow", int'(underflow), 0);
        clr_req++;
        repeat (3) @(negedge pclk);
        check("tlast_err_cleared", int'(tlast_err), 0);

        // enable dropped during ACTIVE: frame completes, then idle
        wait_tready(100);
        per_chk = 0;
        enable = 1'b0;
        check("busy_after_enable_drop", int'(busy), 1);
        wait_fd(100);
        repeat (2) @(negedge pclk);
        check("busy_after_last_frame", int'(busy), 0);
        idle_window(70);

        // One-cycle enable pulse in IDLE: exactly one frame
        enable = 1'b1;
        @(negedge pclk);
        enable = 1'b0;
        check("busy_after_pulse", int'(busy), 1);
        wait_fd(100);
        repeat (2) @(negedge pclk);
        check("busy_after_pulse_frame", int'(busy), 0);
        idle_window(70);

        // Reset while byte 3 of a line is on the bus
        enable = 1'b1;
        wait_tready(100);
        repeat (4) @(negedge pclk);
        check("byte3_href", int'(href), 1);
        check("byte3_data", int'(data), 8'hE0);
        resetn = 1'b0;
        @(negedge pclk);
        check_reset_outputs("midline_reset");
        q.delete();
        resetn = 1'b1;
        @(negedge pclk);
        check("release_vsync_1", int'(vsync), 0);
        check("release_busy", int'(busy), 1);
        @(negedge pclk);
        check("release_vsync_2", int'(vsync), 1);
        enable = 1'b0;
        wait_fd(100);
        repeat (2) @(negedge pclk);
        check("final_busy", int'(busy), 0);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
